// File: rtl/palette_pkg.sv
// Shared constants and state types for the palette mixer slice.
package palette_pkg;

    localparam int PAL_ADDR_W = 13;
    localparam int PAL_DATA_W = 16;
    localparam int PAL_BANK_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } dma_state_t;

    typedef enum logic [1:0] {
        VIDEO,
        CPU,
        DMA,
        NONE
    } port_owner_t;

endpackage

// File: rtl/pal_layer_select.sv
// Picks the winning layer: highest valid+priority, else highest valid, else layer 0.
module pal_layer_select #(
    parameter int LAYERS  = 3,
    parameter int COLOR_W = 11,
    parameter int BANK_W  = 2
) (
    input  logic [LAYERS*COLOR_W-1:0] i_color,
    input  logic [LAYERS*BANK_W-1:0]  i_bank,
    input  logic [LAYERS-1:0]         i_valid,
    input  logic [LAYERS-1:0]         i_prio,
    output logic [2:0]                o_win,
    output logic [BANK_W+COLOR_W-1:0] o_addr
);

    logic                      w_prio_hit;
    logic                      w_valid_hit;
    logic [2:0]                w_prio_idx;
    logic [2:0]                w_valid_idx;
    logic [BANK_W+COLOR_W-1:0] w_prio_addr;
    logic [BANK_W+COLOR_W-1:0] w_valid_addr;

    // Ascending scan so the last hit recorded is the highest index.
    always_comb begin
        w_prio_hit   = 1'b0;
        w_valid_hit  = 1'b0;
        w_prio_idx   = '0;
        w_valid_idx  = '0;
        w_prio_addr  = '0;
        w_valid_addr = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if (i_valid[i] && i_prio[i]) begin
                w_prio_hit  = 1'b1;
                w_prio_idx  = 3'(i);
                w_prio_addr = {i_bank[i*BANK_W +: BANK_W], i_color[i*COLOR_W +: COLOR_W]};
            end
            if (i_valid[i]) begin
                w_valid_hit  = 1'b1;
                w_valid_idx  = 3'(i);
                w_valid_addr = {i_bank[i*BANK_W +: BANK_W], i_color[i*COLOR_W +: COLOR_W]};
            end
        end

        if (w_prio_hit) begin
            o_win  = w_prio_idx;
            o_addr = w_prio_addr;
        end else if (w_valid_hit) begin
            o_win  = w_valid_idx;
            o_addr = w_valid_addr;
        end else begin
            o_win  = '0;
            o_addr = {i_bank[BANK_W-1:0], i_color[COLOR_W-1:0]};
        end
    end

endmodule

// File: rtl/spram.sv
// Single-port RAM with registered read; read-during-write returns the old word.
module spram #(
    parameter int widthad = 8,
    parameter int width   = 8
) (
    input  logic               clk,
    input  logic [widthad-1:0] address,
    input  logic               wren,
    input  logic [width-1:0]   data,
    output logic [width-1:0]   q
);

    logic [width-1:0] r_mem [2**widthad];

    always_ff @(posedge clk) begin
        if (wren) begin
            r_mem[address] <= data;
        end
        q <= r_mem[address];
    end

endmodule

// File: rtl/palette_mixer.sv
// Layer mixer plus banked palette RAM shared between video, CPU port and a bank-copy engine.
module palette_mixer
    import palette_pkg::*;
#(
    parameter int ADDR_W = PAL_ADDR_W,
    parameter int DATA_W = PAL_DATA_W,
    parameter int BANK_W = PAL_BANK_W,
    parameter int LAYERS = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               ce_pix,
    input  logic [LAYERS*(ADDR_W-BANK_W)-1:0]  layer_color,
    input  logic [LAYERS*BANK_W-1:0]           layer_bank,
    input  logic [LAYERS-1:0]                  layer_valid,
    input  logic [LAYERS-1:0]                  layer_prio,
    input  logic                               cpu_req,
    input  logic                               cpu_we,
    input  logic [ADDR_W-1:0]                  cpu_addr,
    input  logic [DATA_W-1:0]                  cpu_din,
    output logic [DATA_W-1:0]                  cpu_dout,
    output logic                               cpu_ack,
    input  logic                               dma_start,
    input  logic [BANK_W-1:0]                  dma_src_bank,
    input  logic [BANK_W-1:0]                  dma_dst_bank,
    output logic                               dma_busy,
    output logic [DATA_W-1:0]                  rgb_out
);

    localparam int COLOR_W = ADDR_W - BANK_W;

    port_owner_t         w_owner;
    logic [2:0]          w_unused_win;
    logic [ADDR_W-1:0]   w_vid_addr;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic                w_ram_we;
    logic [DATA_W-1:0]   w_ram_din;
    logic [DATA_W-1:0]   w_ram_q;

    logic                r_vid_pend;
    logic [DATA_W-1:0]   r_rgb;
    logic                r_cpu_ack;
    logic                r_cpu_wr;
    logic [DATA_W-1:0]   r_cpu_wdata;

    dma_state_t          r_state;
    logic [COLOR_W-1:0]  r_idx;
    logic [BANK_W-1:0]   r_src;
    logic [BANK_W-1:0]   r_dst;
    logic [DATA_W-1:0]   r_dma_data;
    logic                r_rd_pend;
    logic                r_dma_busy;

    pal_layer_select #(
        .LAYERS  (LAYERS),
        .COLOR_W (COLOR_W),
        .BANK_W  (BANK_W)
    ) u_select (
        .i_color (layer_color),
        .i_bank  (layer_bank),
        .i_valid (layer_valid),
        .i_prio  (layer_prio),
        .o_win   (w_unused_win),
        .o_addr  (w_vid_addr)
    );

    // The ack cycle blocks the CPU so a request still held there is not served twice.
    always_comb begin
        w_owner = NONE;
        if (ce_pix) begin
            w_owner = VIDEO;
        end else if (cpu_req && !r_cpu_ack) begin
            w_owner = CPU;
        end else if (r_dma_busy) begin
            w_owner = DMA;
        end
    end

    always_comb begin
        w_ram_addr = w_vid_addr;
        w_ram_we   = 1'b0;
        w_ram_din  = cpu_din;
        case (w_owner)
            CPU: begin
                w_ram_addr = cpu_addr;
                w_ram_we   = cpu_we;
            end
            DMA: begin
                if (r_state == WR) begin
                    w_ram_addr = {r_dst, r_idx};
                    w_ram_we   = 1'b1;
                    // Write right after the read: the word is still on the RAM output.
                    w_ram_din  = r_rd_pend ? w_ram_q : r_dma_data;
                end else begin
                    w_ram_addr = {r_src, r_idx};
                end
            end
            default: ;
        endcase
    end

    spram #(
        .widthad (ADDR_W),
        .width   (DATA_W)
    ) PALRAM (
        .clk     (clk),
        .address (w_ram_addr),
        .wren    (w_ram_we),
        .data    (w_ram_din),
        .q       (w_ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vid_pend  <= 1'b0;
            r_rgb       <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_wr    <= 1'b0;
            r_cpu_wdata <= '0;
        end else begin
            r_vid_pend <= (w_owner == VIDEO);
            if (r_vid_pend) begin
                r_rgb <= w_ram_q;
            end
            r_cpu_ack <= (w_owner == CPU);
            if (w_owner == CPU) begin
                r_cpu_wr    <= cpu_we;
                r_cpu_wdata <= cpu_din;
            end
        end
    end

    // Bank copy: one read slot then one write slot per entry; states hold while starved.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_dma_data <= '0;
            r_rd_pend  <= 1'b0;
            r_dma_busy <= 1'b0;
        end else begin
            r_rd_pend <= 1'b0;
            if (r_rd_pend) begin
                r_dma_data <= w_ram_q;
            end
            case (r_state)
                IDLE: begin
                    if (dma_start) begin
                        r_src      <= dma_src_bank;
                        r_dst      <= dma_dst_bank;
                        r_idx      <= '0;
                        r_state    <= RD;
                        r_dma_busy <= 1'b1;
                    end
                end
                RD: begin
                    if (w_owner == DMA) begin
                        r_rd_pend <= 1'b1;
                        r_state   <= WR;
                    end
                end
                WR: begin
                    if (w_owner == DMA) begin
                        if (&r_idx) begin
                            r_state    <= IDLE;
                            r_dma_busy <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= RD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rgb_out  = r_rgb;
    assign cpu_ack  = r_cpu_ack;
    assign dma_busy = r_dma_busy;
    assign cpu_dout = r_cpu_ack ? (r_cpu_wr ? r_cpu_wdata : w_ram_q) : '0;

endmodule

// File: doc/palette_mixer.md
# palette_mixer

Parametrised palette RAM and layer mixer. It sits between the tile/sprite layer generators and the video output. Each pixel slot, it selects one of `LAYERS` colour indices by valid/priority rules and looks the result up in a banked palette RAM. In the free clock slots it serves a handshaked CPU port and an internal bank-to-bank copy engine.

## Interface
Parameters:
- `ADDR_W`, 13, palette RAM address width (2^ADDR_W entries)
- `DATA_W`, 16, palette word width (xBGR)
- `BANK_W`, 2, bank select width; `COLOR_W = ADDR_W - BANK_W` (derived, 11 by default)
- `LAYERS`, 3, number of layer inputs, 1..8; index 0 is the background

Ports:
- `clk` in 1: system clock
- `reset_n` in 1: asynchronous, active-low reset
- `ce_pix` in 1: pixel slot strobe
- `layer_color` in LAYERS*COLOR_W: colour index per layer; layer i occupies bits [i*COLOR_W +: COLOR_W]
- `layer_bank` in LAYERS*BANK_W: palette bank per layer
- `layer_valid` in LAYERS: layer pixel is opaque
- `layer_prio` in LAYERS: layer pixel is high priority
- `cpu_req` in 1: access request, held until `cpu_ack`
- `cpu_we` in 1: 1 = write
- `cpu_addr` in ADDR_W: word address
- `cpu_din` in DATA_W: write data
- `cpu_dout` out DATA_W: read data, valid while `cpu_ack`=1
- `cpu_ack` out 1: one-cycle completion pulse
- `dma_start` in 1: pulse; starts a bank copy
- `dma_src_bank` in BANK_W: copy source bank; sampled on `dma_start`
- `dma_dst_bank` in BANK_W: copy destination bank; sampled on `dma_start`
- `dma_busy` out 1: copy in progress
- `rgb_out` out DATA_W: palette colour of the current pixel

## Operation
- **Layer select** (combinational, when `ce_pix`=1):
  - The winner is the highest-index layer with `valid & prio`.
  - Otherwise, the highest-index layer with `valid`.
  - Otherwise, layer 0, unconditionally.
  - Video address = {`layer_bank[w]`, `layer_color[w]`}.
- **RAM port ownership per clk**, in priority order:
  - video, when `ce_pix`=1;
  - else CPU, when `cpu_req`=1 and the block is not in a CPU ack cycle;
  - else DMA, when `dma_busy`=1;
  - else idle.
  - Only one access per clk; the RAM read is synchronous with 1-cycle latency.
- **CPU**:
  - A grant at cycle G reads or writes the RAM.
  - `cpu_ack`=1 at G+1; `cpu_dout` holds the RAM data for reads, the written data for writes.
  - `cpu_req` is ignored during the ack cycle, so one held request is never granted twice.
  - A request arriving on a `ce_pix` cycle waits.
- **DMA FSM**, with a COLOR_W-bit index counter `idx`:
  - IDLE: on `dma_start`, latch src/dst, set `idx`=0, go to RD; `dma_busy`=1.
  - RD: on a DMA-owned clk, read {src,`idx`} and go to WR.
  - WR: on a DMA-owned clk, write the captured word to {dst,`idx`}.
    - If `idx` = all-ones, go to IDLE and set `dma_busy`=0.
    - Otherwise increment `idx` and go to RD.
  - While waiting for a slot, the state is held. The read data is captured in a register on the clk after the RD access, so a stalled WR never loses data.
  - `dma_start` while busy is ignored.
  - src == dst runs normally: it rewrites identical data.
- **CPU writes during DMA** commit normally. A CPU write to a dst entry not yet copied is later overwritten by the copy.
- **Reset** (`reset_n`=0, at any time, including mid-copy or mid-CPU access):
  - `rgb_out`=0, `cpu_dout`=0, `cpu_ack`=0, `dma_busy`=0.
  - FSM goes to IDLE, `idx`=0.
  - RAM contents are undefined and not cleared.

## Timing
- **Video**: `ce_pix` at clk N issues the RAM read; `rgb_out` loads the RAM output at clk N+1.
  - `rgb_out` is held between updates.
  - Latency is 1 clk from the pixel slot.
- `ce_pix` high on consecutive clks is legal. Each such clk is a video slot, and CPU/DMA stall until the first `ce_pix`=0 clk.
- **CPU latency**: at best 1 clk from `cpu_req` to `cpu_ack`; worst case (DMA has no priority over the CPU) is bounded by the `ce_pix` run length + 1.
- **DMA duration**: at best 2·2^COLOR_W free clks per bank.

## Structure
- Package `palette_pkg`:
  - default `ADDR_W`/`DATA_W`/`BANK_W` constants
  - `dma_state_t` enum: IDLE, RD, WR
  - `port_owner_t` enum: VIDEO, CPU, DMA, NONE
- Sub-module `pal_layer_select`: purely combinational priority encoder, LAYERS-generic; outputs the winner's index and address.
- RAM: existing single-port registered-read RAM primitive, `widthad=ADDR_W`, `width=DATA_W`, name "PALRAM".

## Test plan
- **Layer priority**: LAYERS=3, valid=3'b011, prio=3'b001 → layer 0 wins. With valid=3'b110, prio=0 → layer 2 wins. With valid=0 → layer 0 address used.
- **CPU round trip**: write 0x7C1F to 0x1234 with `ce_pix`=0 → ack 1 clk later. Read 0x1234 → `cpu_dout`=0x7C1F with ack.
- **Slot contention**: `cpu_req` raised on a `ce_pix`=1 clk → no ack that clk; ack 1 clk after the next `ce_pix`=0 clk. `rgb_out` shows the video word, not CPU data.
- **DMA copy**: fill bank 1 with value = index, start src=1, dst=3 with `ce_pix` toggling 1-of-4 → `dma_busy` deasserts after the full bank; bank 3 matches bank 1 at all 2048 entries.
- **DMA vs CPU**: CPU write 0xFFFF to {3,0x7FF} mid-copy, before that entry is copied → final value equals the source word. A second `dma_start` while busy → ignored.
- **Reset mid-copy**: assert `reset_n`=0 during WR → `dma_busy`=0, `cpu_ack`=0, `rgb_out`=0 immediately. A new `dma_start` after release restarts at `idx`=0.
